// File: rtl/id_entry_if.sv
// Row/column ID entry bus: button and selector in, captured ID and status out.
// The controller uses the slave modport; the driver/consumer side uses master.
interface id_entry_if #(
    parameter int SEL_W = 2
);
    logic             apt;
    logic [SEL_W-1:0] sel;
    logic             id_ack;
    logic [SEL_W-1:0] row;
    logic [SEL_W-1:0] col;
    logic             id_valid;
    logic             timeout;
    logic [2:0]       state_now;

    modport master (
        output apt, sel, id_ack,
        input  row, col, id_valid, timeout, state_now
    );

    modport slave (
        input  apt, sel, id_ack,
        output row, col, id_valid, timeout, state_now
    );
endinterface

// File: rtl/id_entry_ctrl.sv
// Two-step row/column ID entry from one push button, with valid/ack hand-off.
// Define ID_TIMEOUT_EN to build the inactivity counter that aborts a half-entered ID.
module id_entry_ctrl #(
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 10
) (
    input  logic       clk,
    input  logic       rst,
    id_entry_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROW_HELD = 3'd1,
        WAIT_COL = 3'd2,
        COL_HELD = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic             apt_q;
    logic             press, rel;
    logic             abort;
    logic             row_ld, col_ld, id_clr, id_valid;
    logic [SEL_W-1:0] row, col;

    // apt_q resets high so a button held through reset never reads as a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) apt_q <= 1'b1;
        else     apt_q <= bus.apt;
    end

    assign press = bus.apt & ~apt_q;
    assign rel   = ~bus.apt & apt_q;

`ifdef ID_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             timeout_q;

    assign active = (state == ROW_HELD) || (state == WAIT_COL) || (state == COL_HELD);
    // A press on the limit edge wins over the abort
    assign abort  = active && !press && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= '0;
        else if (!active || press || abort) cnt <= '0;
        else                              cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= abort;
    end

    assign bus.timeout = timeout_q;
`else
    assign abort       = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (press) state_nxt = ROW_HELD;
            ROW_HELD: if (abort) state_nxt = IDLE;
                      else if (rel) state_nxt = WAIT_COL;
            WAIT_COL: if (press) state_nxt = COL_HELD;
                      else if (abort) state_nxt = IDLE;
            COL_HELD: if (abort) state_nxt = IDLE;
                      else if (rel) state_nxt = DONE;
            DONE:     if (bus.id_ack) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // DONE ignores presses, so a press coinciding with the ack is dropped
    always_comb begin
        row_ld   = 1'b0;
        col_ld   = 1'b0;
        id_clr   = 1'b0;
        id_valid = 1'b0;
        case (state)
            IDLE:     row_ld   = press;
            WAIT_COL: col_ld   = press;
            DONE:     id_valid = 1'b1;
            default:  ;
        endcase
        if (abort) id_clr = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (id_clr) begin
            row <= '0;
            col <= '0;
        end else if (row_ld) begin
            row <= bus.sel;
            col <= '0;
        end else if (col_ld) begin
            col <= bus.sel;
        end
    end

    assign bus.row       = row;
    assign bus.col       = col;
    assign bus.id_valid  = id_valid;
    assign bus.state_now = state;
endmodule

// File: doc/id_entry_ctrl.md
# id_entry_ctrl

Controller that sequences two-step row/column ID entry from a single push button and a selector bus. It detects press/release edges, captures the row then the column, and aborts a half-entered ID on inactivity timeout. It delivers the finished ID to the downstream consumer through a valid/ack handshake. It sits between the debounced button/switch inputs and the consumer that uses the ID.

## Interface
- `SEL_W`, 2: width of the `sel`, `row` and `col` buses.
- `TIMEOUT`, 1000: inactivity limit in clock cycles; legal range 2..2^`CNT_W`.
- `CNT_W`, 10: width of the timeout counter.

- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `apt`, in, 1: button level, high = pressed. Already debounced and synchronous to `clk`.
- `sel`, in, `SEL_W`: selector value captured on a press.
- `id_ack`, in, 1: consumer accepts the ID.
- `row`, out, `SEL_W`: captured row. Reset value 0.
- `col`, out, `SEL_W`: captured column. Reset value 0.
- `id_valid`, out, 1: ID complete and held. Reset value 0.
- `timeout`, out, 1: one-cycle pulse on abort. Reset value 0.
- `state_now`, out, 3: current state code. Reset value 0.

## Operation
- Edge detection:
  - `apt_q` registers `apt`. Its reset value is 1, so a button held through reset is not a press.
  - press = `apt & ~apt_q`; release = `~apt & apt_q`.
- States and codes: IDLE=0, ROW_HELD=1, WAIT_COL=2, COL_HELD=3, DONE=4. Codes 5–7 recover to IDLE on the next edge.
- IDLE
  - On a press: `row` <= `sel`, `col` <= 0, go to ROW_HELD.
- ROW_HELD
  - On a release: go to WAIT_COL.
- WAIT_COL
  - On a press: `col` <= `sel`, go to COL_HELD.
- COL_HELD
  - On a release: `id_valid` <= 1, go to DONE.
- DONE
  - `row`, `col` and `id_valid` are held stable.
  - Presses and releases are ignored.
  - On `id_ack`=1: `id_valid` <= 0, go to IDLE.
- Timeout counter (`ID_TIMEOUT_EN` defined):
  - Runs in ROW_HELD, WAIT_COL and COL_HELD.
  - Clears on entry from IDLE and on every press.
  - Holds at 0 in IDLE and DONE.
  - When the counter equals `TIMEOUT`-1 and no press occurs that cycle: go to IDLE, clear `row` and `col` to 0, pulse `timeout` for one cycle.
  - A button held past the limit also aborts.
- `id_ack` outside DONE is ignored.

## Timing
- A press is acted on at the first rising edge where `apt`=1 is sampled with `apt_q`=0. The state changes at that same edge.
- `id_valid` rises at the edge where the column release is sampled. That is 0 cycles of extra latency after the release is sampled.
- `id_valid` falls at the edge where `id_ack`=1 is sampled in DONE. The earliest new press is recognised one edge later.
- Timeout edge ordering:
  - An abort fires `TIMEOUT` edges after the last counter clear.
  - A press on that same edge wins: no abort, and the counter clears.
  - A release on that same edge loses: abort.
- If `id_ack` and a press coincide in DONE, the ack is taken and the press is dropped. `apt_q` still updates, so the press is not re-detected.
- Reset asserted in any state, including mid-entry: all outputs and the counter go to reset values immediately, state goes to IDLE, and `apt_q` goes to 1.

## Configuration
- `ID_TIMEOUT_EN` defined: the timeout counter and abort logic are built as described.
- `ID_TIMEOUT_EN` undefined:
  - No counter is built, and `timeout` is tied to 0.
  - Entry waits indefinitely in ROW_HELD, WAIT_COL and COL_HELD.
  - `TIMEOUT` and `CNT_W` are unused.

## Test plan
All scenarios use `SEL_W`=2, `TIMEOUT`=8 and `ID_TIMEOUT_EN` defined.
- **Normal entry:**
  - Stimulus: press with `sel`=2, release, press with `sel`=1, release, then `id_ack` 3 cycles later.
  - Required response: `row`=2, `col`=1, `id_valid`=1 from the release edge until the ack edge, `state_now` sequence 0,1,2,3,4,0.
- **Timeout in WAIT_COL:**
  - Stimulus: row entered with `sel`=3, button released, then idle.
  - Required response: exactly 8 edges after the press, `timeout` pulses for one cycle, `row`=0, `state_now`=0, `id_valid` never rises.
- **Press on the limit edge:**
  - Stimulus: column press lands on the 8th edge after the row press.
  - Required response: no `timeout`, `col` captured, `state_now`=3.
- **DONE lock-out and simultaneous ack:**
  - Stimulus: extra presses with `sel`=0 in DONE, then `id_ack` coinciding with a press.
  - Required response: `row`/`col` unchanged, transition to IDLE, no capture, `state_now`=0.
- **Reset:**
  - Stimulus: async `rst` pulse mid-COL_HELD, with the button still held as `rst` falls.
  - Required response: all outputs 0 immediately; no press detected until `apt` goes low then high.
- **Build variant:**
  - Stimulus: build without `ID_TIMEOUT_EN` and hold WAIT_COL for 100 cycles.
  - Required response: `timeout` stays 0 and `state_now` stays 2.
